// File: rtl/nspi_pkg.sv
// Shared definitions for the nspi receiver/transmitter pair: FSM state
// encoding, SPI clock idle level and default bus geometry.
package nspi_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RECEIVE = 1'b1
    } nspi_state_e;

    localparam logic SPI_CLK_IDLE          = 1'b0;
    localparam int   NSPI_DEFAULT_CHANNELS = 2;
    localparam int   NSPI_DEFAULT_SIZE     = 8;

endpackage

// File: rtl/nspi_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Synchronous active-high reset clears both stages.
module nspi_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    // Two register stages to resolve metastability before any use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    assign o_q = r_sync2;

endmodule

// File: rtl/nspi_rx.sv
// Multi-channel SPI receiver: CHANNEL_NUMBER MOSI lines share one SPI
// clock, which is oversampled on clk after synchronization.
// Optional feature macro NSPI_RX_TIMEOUT_EN: abandons a partial word after
// TIMEOUT_CYCLES clk cycles without an SPI clock edge.
//
// state   | meaning
// IDLE    | no bits of the current word received (bit count 0)
// RECEIVE | word partially received, rx_busy high
module nspi_rx
    import nspi_pkg::*;
#(
    parameter int CHANNEL_NUMBER = NSPI_DEFAULT_CHANNELS,
    parameter int SPI_SIZE       = NSPI_DEFAULT_SIZE,
    parameter int MSB_FIRST      = 1
`ifdef NSPI_RX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_clk,
    input  logic [CHANNEL_NUMBER-1:0] spi_mosi,
    output logic [SPI_SIZE-1:0]       data_out [CHANNEL_NUMBER-1:0],
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      rx_overrun,
    output logic                      rx_busy
);

    localparam int CNT_W = (SPI_SIZE > 1) ? $clog2(SPI_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SPI_SIZE - 1);

    logic                      w_sclk_s;
    logic [CHANNEL_NUMBER-1:0] w_mosi_s;
    logic                      r_sclk_prev;
    logic                      w_edge;
    logic                      w_complete;
    logic                      w_abort;
    logic [CNT_W-1:0]          r_bit_cnt;
    nspi_state_e               r_state;
    nspi_state_e               w_state_next;
    logic [SPI_SIZE-1:0]       r_shift      [CHANNEL_NUMBER-1:0];
    logic [SPI_SIZE-1:0]       w_shift_next [CHANNEL_NUMBER-1:0];
    logic [SPI_SIZE-1:0]       r_data       [CHANNEL_NUMBER-1:0];
    logic                      r_valid;
    logic                      r_overrun;

    nspi_sync #(.WIDTH(1)) u_sync_clk (
        .clk (clk),
        .rst (rst),
        .i_d (spi_clk),
        .o_q (w_sclk_s)
    );

    nspi_sync #(.WIDTH(CHANNEL_NUMBER)) u_sync_mosi (
        .clk (clk),
        .rst (rst),
        .i_d (spi_mosi),
        .o_q (w_mosi_s)
    );

    // Edge history of the synchronized SPI clock.
    always_ff @(posedge clk) begin
        if (rst) r_sclk_prev <= 1'b0;
        else     r_sclk_prev <= w_sclk_s;
    end

    assign w_edge     = (w_sclk_s != SPI_CLK_IDLE) && (r_sclk_prev == SPI_CLK_IDLE);
    assign w_complete = w_edge && (r_bit_cnt == LAST_BIT);

    for (genvar c = 0; c < CHANNEL_NUMBER; c++) begin : g_shift
        if (SPI_SIZE == 1) begin : g_one
            assign w_shift_next[c] = w_mosi_s[c];
        end else if (MSB_FIRST != 0) begin : g_msb
            assign w_shift_next[c] = {r_shift[c][SPI_SIZE-2:0], w_mosi_s[c]};
        end else begin : g_lsb
            assign w_shift_next[c] = {w_mosi_s[c], r_shift[c][SPI_SIZE-1:1]};
        end
    end

    // Shift every channel on each SPI rising edge; latch the finished word.
    always_ff @(posedge clk) begin
        for (int c = 0; c < CHANNEL_NUMBER; c++) begin
            if (rst) begin
                r_shift[c] <= '0;
                r_data[c]  <= '0;
            end else begin
                if (w_edge)     r_shift[c] <= w_shift_next[c];
                if (w_complete) r_data[c]  <= w_shift_next[c];
            end
        end
    end

`ifdef NSPI_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;

    // Down-counter of edge-free cycles in RECEIVE; reloads on any edge.
    always_ff @(posedge clk) begin
        if (rst)
            r_to_cnt <= TO_W'(TIMEOUT_CYCLES);
        else if (r_state != RECEIVE || w_edge)
            r_to_cnt <= TO_W'(TIMEOUT_CYCLES);
        else if (r_to_cnt != '0)
            r_to_cnt <= r_to_cnt - TO_W'(1);
    end

    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without an edge.
    assign w_abort = (r_state == RECEIVE) && !w_edge && (r_to_cnt == TO_W'(1));
`else
    assign w_abort = 1'b0;
`endif

    // Bit position within the current word; wraps on the last bit.
    always_ff @(posedge clk) begin
        if (rst)
            r_bit_cnt <= '0;
        else if (w_abort)
            r_bit_cnt <= '0;
        else if (w_edge)
            r_bit_cnt <= w_complete ? '0 : r_bit_cnt + CNT_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next state; a single-bit word completes on its first edge and never leaves IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_edge && !w_complete)   w_state_next = RECEIVE;
            RECEIVE: if (w_complete || w_abort)   w_state_next = IDLE;
            default:                              w_state_next = IDLE;
        endcase
    end

    // Output handshake: a new word always wins over a same-cycle acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= w_complete && r_valid && !rx_ready;
            if (w_complete)
                r_valid <= 1'b1;
            else if (r_valid && rx_ready)
                r_valid <= 1'b0;
        end
    end

    // Status outputs are forced low combinationally so they read 0 for the
    // whole time rst is asserted, including before the first reset edge.
    assign data_out   = r_data;
    assign rx_valid   = r_valid && !rst;
    assign rx_overrun = r_overrun && !rst;
    assign rx_busy    = (r_state == RECEIVE) && !rst;

endmodule

// File: tb/tb_nspi_rx.sv
// Directed bench for nspi_rx: one MSB-first and one LSB-first instance
// listen to the same serial stream driven by a behavioural transmitter.
module tb_nspi_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic [1:0] spi_mosi;
    logic       rx_ready;

    logic [7:0] data_m [1:0];
    logic       valid_m, ovr_m, busy_m;
    logic [7:0] data_l [1:0];
    logic       valid_l, ovr_l, busy_l;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_valid = 0;
    int cnt_ovr   = 0;
    int cnt_ovr_l = 0;

    logic [7:0] lb0 [4];
    logic [7:0] lb1 [4];

    always #5 clk = ~clk;

    nspi_rx #(.CHANNEL_NUMBER(2), .SPI_SIZE(8), .MSB_FIRST(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .data_out   (data_m),
        .rx_valid   (valid_m),
        .rx_ready   (rx_ready),
        .rx_overrun (ovr_m),
        .rx_busy    (busy_m)
    );

    nspi_rx #(.CHANNEL_NUMBER(2), .SPI_SIZE(8), .MSB_FIRST(0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .data_out   (data_l),
        .rx_valid   (valid_l),
        .rx_ready   (rx_ready),
        .rx_overrun (ovr_l),
        .rx_busy    (busy_l)
    );

    always @(negedge clk) begin
        if (valid_m) cnt_valid++;
        if (ovr_m)   cnt_ovr++;
        if (ovr_l)   cnt_ovr_l++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bits hi..lo of each word, MSB of the word first on the wire.
    task automatic send_bits(input logic [7:0] w0, input logic [7:0] w1,
                             input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            spi_mosi = {w1[i], w0[i]};
            idle(3);
            spi_clk = 1'b1;
            idle(3);
            spi_clk = 1'b0;
        end
    endtask

    task automatic send_word(input logic [7:0] w0, input logic [7:0] w1);
        send_bits(w0, w1, 7, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        spi_clk  = 1'b0;
        spi_mosi = 2'b00;
        rx_ready = 1'b1;
        idle(3);
        chk("reset_valid", {31'd0, valid_m}, 32'd0);
        chk("reset_busy",  {31'd0, busy_m},  32'd0);
        chk("reset_ovr",   {31'd0, ovr_m},   32'd0);
        chk("reset_data0", {24'd0, data_m[0]}, 32'h00);
        rst = 1'b0;
        idle(3);

        // Basic word, consumer always ready.
        cnt_valid = 0;
        send_word(8'h0F, 8'hF0);
        idle(8);
        chk("basic_d0",     {24'd0, data_m[0]}, 32'h0F);
        chk("basic_d1",     {24'd0, data_m[1]}, 32'hF0);
        chk("basic_vcycles", cnt_valid, 32'd1);
        chk("basic_busy",   {31'd0, busy_m}, 32'd0);
        chk("lsb_basic_d0", {24'd0, data_l[0]}, 32'hF0);
        chk("lsb_basic_d1", {24'd0, data_l[1]}, 32'h0F);

        // Stream 1,0,0,0,0,0,0,0 on ch0.
        send_word(8'h80, 8'h00);
        idle(8);
        chk("lsb_first_d0", {24'd0, data_l[0]}, 32'h01);
        chk("msb_first_d0", {24'd0, data_m[0]}, 32'h80);

        // Overrun: two words with the consumer stalled.
        rx_ready = 1'b0;
        cnt_ovr  = 0;
        cnt_ovr_l = 0;
        send_word(8'hA5, 8'h5A);
        idle(8);
        chk("ovr_first_valid", {31'd0, valid_m}, 32'd1);
        chk("ovr_first_d0",    {24'd0, data_m[0]}, 32'hA5);
        chk("ovr_first_count", cnt_ovr, 32'd0);
        send_word(8'h3C, 8'hC3);
        idle(8);
        chk("ovr_count",   cnt_ovr, 32'd1);
        chk("ovr_count_l", cnt_ovr_l, 32'd1);
        chk("ovr_d0",      {24'd0, data_m[0]}, 32'h3C);
        chk("ovr_d1",      {24'd0, data_m[1]}, 32'hC3);
        chk("ovr_valid",   {31'd0, valid_m}, 32'd1);
        chk("ovr_valid_l", {31'd0, valid_l}, 32'd1);
        rx_ready = 1'b1;
        idle(2);
        chk("ovr_consumed", {31'd0, valid_m}, 32'd0);

        // Reset in the middle of a word.
        send_bits(8'hFF, 8'hFF, 7, 4);
        idle(2);
        chk("mid_busy", {31'd0, busy_m}, 32'd1);
        rst = 1'b1;
        idle(1);
        chk("rst_busy",   {31'd0, busy_m}, 32'd0);
        chk("rst_busy_l", {31'd0, busy_l}, 32'd0);
        chk("rst_valid",  {31'd0, valid_m}, 32'd0);
        idle(1);
        chk("rst_data0",  {24'd0, data_m[0]}, 32'h00);
        rst = 1'b0;
        idle(2);
        cnt_valid = 0;
        send_word(8'h81, 8'h7E);
        idle(8);
        chk("post_rst_d0", {24'd0, data_m[0]}, 32'h81);
        chk("post_rst_d1", {24'd0, data_m[1]}, 32'h7E);
        chk("post_rst_vcycles", cnt_valid, 32'd1);

        // Stall mid-word for 100 cycles.
        cnt_valid = 0;
        send_bits(8'h55, 8'hAA, 7, 5);
        idle(100);
`ifdef NSPI_RX_TIMEOUT_EN
        chk("to_busy",   {31'd0, busy_m}, 32'd0);
        chk("to_nvalid", cnt_valid, 32'd0);
        send_word(8'h55, 8'hAA);
`else
        chk("stall_busy",   {31'd0, busy_m}, 32'd1);
        chk("stall_nvalid", cnt_valid, 32'd0);
        send_bits(8'h55, 8'hAA, 4, 0);
`endif
        idle(8);
        chk("stall_d0",      {24'd0, data_m[0]}, 32'h55);
        chk("stall_d1",      {24'd0, data_m[1]}, 32'hAA);
        chk("stall_vcycles", cnt_valid, 32'd1);

        // Back-to-back transfers from a transmitter model.
        lb0[0] = 8'h12; lb1[0] = 8'hFE;
        lb0[1] = 8'h9C; lb1[1] = 8'h01;
        lb0[2] = 8'hE7; lb1[2] = 8'h6B;
        lb0[3] = 8'h40; lb1[3] = 8'hD3;
        cnt_valid = 0;
        cnt_ovr   = 0;
        for (int k = 0; k < 4; k++) begin
            send_word(lb0[k], lb1[k]);
            idle(4);
            chk($sformatf("lb%0d_d0", k), {24'd0, data_m[0]}, {24'd0, lb0[k]});
            chk($sformatf("lb%0d_d1", k), {24'd0, data_m[1]}, {24'd0, lb1[k]});
        end
        chk("lb_words", cnt_valid, 32'd4);
        chk("lb_ovr",   cnt_ovr,   32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
